// File: rtl/dm_controller.sv
// dm_controller: multi-cycle data-memory slave for the SimpleRISC DM port.
// Holds a 128 x 32-bit word memory and services one load or store at a time.
// Each access takes LATENCY BUSY cycles followed by one DONE cycle with done=1.
//
// Parameters:
//   LATENCY   - wait cycles per access (1..15)
//   INIT_FILE - optional hex image loaded into the memory at simulation start
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous reset, active low
//   ena   - access request, held for the whole access
//   wea   - 1 = store, 0 = load (sampled with ena)
//   addra - word address
//   dina  - store data
//   douta - registered load data, holds the last load result
//   done  - registered one-cycle completion pulse
//   rd_count / wr_count - saturating load/store completion counters,
//                         present only when DM_STATS_EN is defined
// Optional feature macro: DM_STATS_EN
module dm_controller #(
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        wea,
  input  logic [6:0]  addra,
  input  logic [31:0] dina,
  output logic [31:0] douta,
  output logic        done
`ifdef DM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0] mem [128];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [6:0]  addr_q,  addr_d;
  logic        wea_q,   wea_d;
  logic [31:0] din_q,   din_d;
  logic [31:0] douta_q, douta_d;
  logic        done_q,  done_d;
  logic        access_fire;

  // The access happens on the edge that leaves the last BUSY cycle.
  assign access_fire = (state_q == S_BUSY) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wea_d   = wea_q;
    din_d   = din_q;
    douta_d = douta_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ena) begin
          addr_d  = addra;
          wea_d   = wea;
          din_d   = dina;
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (!wea_q) douta_d = mem[addr_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // ena still belongs to the completing instruction, so DONE never accepts.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 7'd0;
      wea_q   <= 1'b0;
      din_q   <= 32'd0;
      douta_q <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wea_q   <= wea_d;
      din_q   <= din_d;
      douta_q <= douta_d;
      done_q  <= done_d;
    end
  end

  // Memory is not reset; reset forces the FSM to IDLE, which blocks a pending store.
  always_ff @(posedge clk) begin
    if (access_fire && wea_q) mem[addr_q] <= din_q;
  end

  assign douta = douta_q;
  assign done  = done_q;

`ifdef DM_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (access_fire && !wea_q) rd_cnt_d = sat_inc(rd_cnt_q);
    if (access_fire &&  wea_q) wr_cnt_d = sat_inc(wr_cnt_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dm_controller.sv
// Testbench for dm_controller: three instances (LATENCY 2, 1, 15) share the
// request fields; each has its own ena. Expected completions are queued when a
// request is driven and checked by a monitor whenever a done pulse appears.
module tb_dm_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wea;
  logic [6:0]  addra;
  logic [31:0] dina;
  logic [2:0]  ena_v;
  logic [2:0]  done_v;
  logic [2:0][31:0] douta_v;
`ifdef DM_STATS_EN
  logic [2:0][15:0] rdc_v;
  logic [2:0][15:0] wrc_v;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          inst;
    logic [31:0] d;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] rmem [3][128];
  logic [31:0] last_rd [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_controller #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst), .ena(ena_v[0]), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta_v[0]), .done(done_v[0])
`ifdef DM_STATS_EN
    , .rd_count(rdc_v[0]), .wr_count(wrc_v[0])
`endif
  );

  dm_controller #(.LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .ena(ena_v[1]), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta_v[1]), .done(done_v[1])
`ifdef DM_STATS_EN
    , .rd_count(rdc_v[1]), .wr_count(wrc_v[1])
`endif
  );

  dm_controller #(.LATENCY(15)) dut_l15 (
    .clk(clk), .rst(rst), .ena(ena_v[2]), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta_v[2]), .done(done_v[2])
`ifdef DM_STATS_EN
    , .rd_count(rdc_v[2]), .wr_count(wrc_v[2])
`endif
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (done_v[k] === 1'b1) begin
        if (sbq.size() == 0) begin
          check_val($sformatf("spurious_done%0d", k), 32'(done_v[k]), 32'd0);
        end else begin
          e = sbq.pop_front();
          check_val("done_inst", k, e.inst);
          check_val($sformatf("done_cyc%0d", k), cyc, e.cyc);
          check_val($sformatf("douta%0d", k), douta_v[k], e.d);
        end
      end
    end
  end

  // mode 0: wait one negedge then request; mode 1: back-to-back from a DONE
  // cycle (accepted one cycle later); mode 2: request in the current cycle.
  task automatic acc(input int k, input logic w, input logic [6:0] a,
                     input logic [31:0] d, input int mode, input bit freeze);
    int   n;
    exp_t e;
    if (mode == 0) @(negedge clk);
    ena_v[k] = 1'b1;
    wea      = w;
    addra    = a;
    dina     = d;
    n = (mode == 1) ? cyc + 1 : cyc;
    if (w) rmem[k][a] = d;
    else   last_rd[k] = rmem[k][a];
    e.inst = k;
    e.d    = last_rd[k];
    e.cyc  = n + lat_of(k) + 1;
    sbq.push_back(e);
    do @(negedge clk); while (cyc < n + 1);
    if (freeze) begin
      addra = a + 7'd1;
      wea   = ~w;
      dina  = ~d;
    end
    while (cyc < e.cyc) @(negedge clk);
    ena_v[k] = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    ena_v = 3'b000;
    wea   = 1'b0;
    addra = 7'd0;
    dina  = 32'd0;
    for (int k = 0; k < 3; k++) last_rd[k] = 32'd0;

    // Reset state, sampled mid-reset
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("rst_done%0d", k), 32'(done_v[k]), 32'd0);
      check_val($sformatf("rst_douta%0d", k), douta_v[k], 32'd0);
    end
    while (cyc != 3) @(negedge clk);
    rst = 1'b1;

    // Store in cycle 10 -> done in cycle 13, then read it back
    while (cyc != 9) @(negedge clk);
    acc(0, 1'b1, 7'h05, 32'hDEADBEEF, 0, 1'b0);
    acc(0, 1'b0, 7'h05, 32'h0, 0, 1'b0);

    // Back-to-back store/load on the last word
    acc(0, 1'b1, 7'h7F, 32'hA5A5_5A5A, 0, 1'b0);
    acc(0, 1'b0, 7'h7F, 32'h0, 1, 1'b0);

    // Field freeze: fields change during BUSY of a load
    acc(0, 1'b1, 7'h10, 32'h1111_1111, 0, 1'b0);
    acc(0, 1'b1, 7'h11, 32'h2222_2222, 0, 1'b0);
    acc(0, 1'b0, 7'h10, 32'h0, 0, 1'b1);
    acc(0, 1'b0, 7'h11, 32'h0, 0, 1'b0);

    // Reset mid-BUSY drops a pending store
    acc(0, 1'b1, 7'h20, 32'hCAFE_F00D, 0, 1'b0);
    acc(0, 1'b0, 7'h05, 32'h0, 0, 1'b0);
    @(negedge clk);
    ena_v[0] = 1'b1;
    wea      = 1'b1;
    addra    = 7'h20;
    dina     = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    ena_v[0] = 1'b0;
    #1;
    check_val("midrst_done", 32'(done_v[0]), 32'd0);
    check_val("midrst_douta", douta_v[0], 32'd0);
    for (int k = 0; k < 3; k++) last_rd[k] = 32'd0;
    @(negedge clk);
    // Release with a load pending: accepted at the first edge after release
    rst = 1'b1;
    acc(0, 1'b0, 7'h20, 32'h0, 2, 1'b0);

    // Latency sweep
    acc(1, 1'b1, 7'h7F, 32'h0BAD_CAFE, 0, 1'b0);
    acc(1, 1'b0, 7'h7F, 32'h0, 1, 1'b0);
    acc(2, 1'b1, 7'h00, 32'h7654_3210, 0, 1'b0);
    acc(2, 1'b0, 7'h00, 32'h0, 1, 1'b0);

`ifdef DM_STATS_EN
    // One load since reset; add two loads and two stores
    acc(0, 1'b1, 7'h30, 32'h3030_3030, 0, 1'b0);
    acc(0, 1'b0, 7'h30, 32'h0, 0, 1'b0);
    acc(0, 1'b1, 7'h31, 32'h3131_3131, 0, 1'b0);
    acc(0, 1'b0, 7'h31, 32'h0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check_val("rd_count", 32'(rdc_v[0]), 32'd3);
    check_val("wr_count", 32'(wrc_v[0]), 32'd2);
    force dut.rd_cnt_q = 16'hFFFF;
    force dut.wr_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.rd_cnt_q;
    release dut.wr_cnt_q;
    acc(0, 1'b0, 7'h30, 32'h0, 0, 1'b0);
    acc(0, 1'b1, 7'h32, 32'h3232_3232, 0, 1'b0);
    repeat (2) @(negedge clk);
    check_val("rd_sat", 32'(rdc_v[0]), 32'h0000_FFFF);
    check_val("wr_sat", 32'(wrc_v[0]), 32'h0000_FFFF);
`endif

    repeat (4) @(negedge clk);
    check_val("sb_drain", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
